// File: rtl/m_meta_buffer.sv
// Metadata FIFO between the control machine and the data controller.
// The head entry is held in an output register so meta_glb_o never comes straight from meta_glb_i.
module m_meta_buffer #(
    parameter int unsigned  Depth         = 4,
    parameter type          meta_glb_t    = logic,
    parameter bit           CheckProducer = 1'b1,
    localparam int unsigned CntW          = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            meta_ctrl_valid_i,
    output logic            meta_ctrl_ready_o,
    input  meta_glb_t       meta_glb_i,
    output logic            meta_valid_o,
    input  logic            meta_ready_i,
    output meta_glb_t       meta_glb_o,
    output logic [CntW-1:0] usage_o,
    output logic            empty_o,
    output logic            overflow_o
);
    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    meta_glb_t       mem [Depth];
    logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CntW-1:0] count_reg, count_next;
    meta_glb_t       head_reg, head_next;
    logic            overflow_reg, overflow_next;
    logic            push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign meta_ctrl_ready_o = (count_reg != FullCnt);
    assign meta_valid_o      = (count_reg != '0);
    assign empty_o           = (count_reg == '0);
    assign usage_o           = count_reg;
    assign overflow_o        = overflow_reg;
    assign meta_glb_o        = head_reg;

    always_comb begin
        push          = meta_ctrl_valid_i && meta_ctrl_ready_o;
        pop           = meta_valid_o && meta_ready_i;
        wr_ptr_next   = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next   = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        overflow_next = overflow_reg || (meta_ctrl_valid_i && !meta_ctrl_ready_o);
        count_next    = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
        // The new head is the slot rd_ptr_next; if this cycle's push lands there, bypass the write.
        head_next = head_reg;
        if (pop || (push && empty_o)) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_next = meta_glb_i;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= meta_glb_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            head_reg     <= head_next;
            overflow_reg <= overflow_next;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) count_reg <= FullCnt);

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (meta_valid_o && !meta_ready_i) |=> $stable(meta_glb_o));

    // Producers that are allowed to probe a full buffer turn this check off.
    if (CheckProducer) begin : g_producer_check
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(meta_ctrl_valid_i && !meta_ctrl_ready_o));
    end

endmodule

// File: tb/tb_m_meta_buffer.sv
// Bench for m_meta_buffer: three instances (Depth 4, 3, 1) share one stimulus stream,
// each compared every cycle against its own queue model, plus directed sequences.
module tb_m_meta_buffer;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cv;
    logic [7:0] cd;
    logic       mr;

    logic [2:0] u4;
    logic [1:0] u3;
    logic [0:0] u1;
    logic [2:0] usage_a [3];
    logic       valid_a [3];
    logic       ready_a [3];
    logic       empty_a [3];
    logic       ovf_a   [3];
    logic [7:0] glb_a   [3];

    int         checks = 0;
    int         errors = 0;
    int         dep [3] = '{4, 3, 1};
    logic [7:0] mq [3][$];
    bit         movf [3];

    always #5 clk_i = ~clk_i;

    assign usage_a[0] = u4;
    assign usage_a[1] = {1'b0, u3};
    assign usage_a[2] = {2'b00, u1};

    m_meta_buffer #(.Depth(4), .meta_glb_t(logic [7:0]), .CheckProducer(1'b0)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .meta_ctrl_valid_i(cv), .meta_ctrl_ready_o(ready_a[0]),
        .meta_glb_i(cd), .meta_valid_o(valid_a[0]), .meta_ready_i(mr), .meta_glb_o(glb_a[0]),
        .usage_o(u4), .empty_o(empty_a[0]), .overflow_o(ovf_a[0]));

    m_meta_buffer #(.Depth(3), .meta_glb_t(logic [7:0]), .CheckProducer(1'b0)) dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .meta_ctrl_valid_i(cv), .meta_ctrl_ready_o(ready_a[1]),
        .meta_glb_i(cd), .meta_valid_o(valid_a[1]), .meta_ready_i(mr), .meta_glb_o(glb_a[1]),
        .usage_o(u3), .empty_o(empty_a[1]), .overflow_o(ovf_a[1]));

    m_meta_buffer #(.Depth(1), .meta_glb_t(logic [7:0]), .CheckProducer(1'b0)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .meta_ctrl_valid_i(cv), .meta_ctrl_ready_o(ready_a[2]),
        .meta_glb_i(cd), .meta_valid_o(valid_a[2]), .meta_ready_i(mr), .meta_glb_o(glb_a[2]),
        .usage_o(u1), .empty_o(empty_a[2]), .overflow_o(ovf_a[2]));

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         r;
        int         usage;
        bit         valid;
        bit         ready;
        logic [7:0] glb;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_models();
        for (int k = 0; k < 3; k++) begin
            int sz;
            sz = mq[k].size();
            check($sformatf("d%0d usage", dep[k]), int'(usage_a[k]), sz);
            check($sformatf("d%0d valid", dep[k]), int'(valid_a[k]), int'(sz != 0));
            check($sformatf("d%0d ready", dep[k]), int'(ready_a[k]), int'(sz != dep[k]));
            check($sformatf("d%0d empty", dep[k]), int'(empty_a[k]), int'(sz == 0));
            check($sformatf("d%0d overflow", dep[k]), int'(ovf_a[k]), int'(movf[k]));
            if (sz != 0) begin
                check($sformatf("d%0d head", dep[k]), int'(glb_a[k]), int'(mq[k][0]));
            end
        end
    endtask

    // One clock: the models consume the inputs present at the edge, outputs are checked on the falling edge.
    task automatic cycle();
        bit mready, mpop;
        @(posedge clk_i);
        for (int k = 0; k < 3; k++) begin
            if (!rst_ni) begin
                mq[k].delete();
                movf[k] = 1'b0;
            end else begin
                mready = (mq[k].size() != dep[k]);
                mpop   = (mq[k].size() != 0) && mr;
                if (cv && !mready) movf[k] = 1'b1;
                if (mpop) void'(mq[k].pop_front());
                if (cv && mready) mq[k].push_back(cd);
            end
        end
        @(negedge clk_i);
        check_models();
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        cv = v;
        cd = d;
        mr = r;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(0, 8'h00, 0);
        for (int k = 0; k < 3; k++) movf[k] = 1'b0;

        tbl[0] = '{1, 8'hA1, 0, 1, 1, 1, 8'hA1};
        tbl[1] = '{1, 8'hA2, 0, 2, 1, 1, 8'hA1};
        tbl[2] = '{1, 8'hA3, 0, 3, 1, 1, 8'hA1};
        tbl[3] = '{1, 8'hA4, 0, 4, 1, 0, 8'hA1};
        tbl[4] = '{0, 8'h00, 1, 3, 1, 1, 8'hA2};
        tbl[5] = '{0, 8'h00, 1, 2, 1, 1, 8'hA3};
        tbl[6] = '{0, 8'h00, 1, 1, 1, 1, 8'hA4};
        tbl[7] = '{0, 8'h00, 1, 0, 0, 1, 8'h00};

        // Reset state
        cycle();
        cycle();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset d%0d glb", dep[k]), int'(glb_a[k]), 0);
            check($sformatf("reset d%0d ready", dep[k]), int'(ready_a[k]), 1);
        end
        rst_ni = 1'b1;

        // Fill then drain, Depth 4
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            cycle();
            check($sformatf("tbl%0d usage", i), int'(u4), tbl[i].usage);
            check($sformatf("tbl%0d valid", i), int'(valid_a[0]), int'(tbl[i].valid));
            check($sformatf("tbl%0d ready", i), int'(ready_a[0]), int'(tbl[i].ready));
            check($sformatf("tbl%0d empty", i), int'(empty_a[0]), int'(tbl[i].usage == 0));
            if (tbl[i].valid) check($sformatf("tbl%0d glb", i), int'(glb_a[0]), int'(tbl[i].glb));
        end

        // Simultaneous push and pop at count 2
        drive(1, 8'h11, 0); cycle();
        drive(1, 8'h22, 0); cycle();
        check("t4 usage before", int'(u4), 2);
        drive(1, 8'h55, 1); cycle();
        check("t4 usage held", int'(u4), 2);
        check("t4 head 22", int'(glb_a[0]), 8'h22);
        drive(0, 8'h00, 1); cycle();
        check("t4 head 55", int'(glb_a[0]), 8'h55);
        cycle();
        check("t4 drained", int'(empty_a[0]), 1);

        // Overflow while full
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'hB0 + 8'(i), 0);
            cycle();
        end
        check("t5 full ready", int'(ready_a[0]), 0);
        check("t5 ovf before", int'(ovf_a[0]), 0);
        drive(1, 8'hFF, 0); cycle();
        check("t5 ovf set", int'(ovf_a[0]), 1);
        check("t5 usage", int'(u4), 4);
        check("t5 head", int'(glb_a[0]), 8'hB0);
        for (int i = 1; i < 4; i++) begin
            drive(0, 8'h00, 1); cycle();
            check($sformatf("t5 drain%0d", i), int'(glb_a[0]), 8'hB0 + i);
        end
        cycle();
        check("t5 empty", int'(empty_a[0]), 1);
        check("t5 ovf sticky", int'(ovf_a[0]), 1);

        // Reset mid-traffic with 3 entries held
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'hC0 + 8'(i), 0);
            cycle();
        end
        check("t1 usage 3", int'(u4), 3);
        drive(1, 8'hC3, 1);
        rst_ni = 1'b0;
        cycle();
        check("t1 usage", int'(u4), 0);
        check("t1 valid", int'(valid_a[0]), 0);
        check("t1 ready", int'(ready_a[0]), 1);
        check("t1 ovf", int'(ovf_a[0]), 0);
        drive(0, 8'h00, 0);
        rst_ni = 1'b1;
        cycle();

        // Latency and backpressure
        drive(1, 8'h12, 0);
        #1;
        check("t6 no fallthrough", int'(valid_a[0]), 0);
        cycle();
        check("t6 valid N+1", int'(valid_a[0]), 1);
        check("t6 glb", int'(glb_a[0]), 8'h12);
        check("t6 d1 ready", int'(ready_a[2]), 0);
        drive(0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("t6 hold%0d", i), int'(glb_a[0]), 8'h12);
        end
        drive(0, 8'h00, 1); cycle();
        check("t6 popped", int'(empty_a[0]), 1);

        // Wrap on Depth 3 at count 1
        drive(1, 8'd0, 0); cycle();
        check("t3 first", int'(glb_a[1]), 0);
        for (int i = 1; i < 10; i++) begin
            drive(1, 8'(i), 1);
            cycle();
            check($sformatf("t3 usage%0d", i), int'(u3), 1);
            check($sformatf("t3 head%0d", i), int'(glb_a[1]), i);
        end
        drive(0, 8'h00, 1); cycle();
        check("t3 empty", int'(empty_a[1]), 1);

        // Randomized traffic against the queue models
        rst_ni = 1'b0; drive(0, 8'h00, 0); cycle();
        rst_ni = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst_ni = ($urandom_range(0, 299) != 0);
            drive($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 50);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
